pixel_fetch: RTL

//  Consumer end of the pixel-map address FIFO. Pops mapped addresses, issues SRAM reads and

---
 rtl/pixel_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/pixel_fetch.sv
// Address-FIFO consumer: pops pixel-map addresses, issues SRAM reads and returns pixels
// in order through an elastic output buffer that primes before streaming to the LCD stage.
module pixel_fetch #(
  parameter int          SRAM_LATENCY = 2,
  parameter int          OUT_DEPTH    = 8,
  parameter int          PRIME_LEVEL  = 4,
  parameter logic [15:0] BLACK_PIXEL  = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [19:0] iADDRESS,
  input  logic        iREADY_N,
  output logic        oREAD,
  output logic [19:0] oSRAM_ADDR,
  output logic        oSRAM_OE_N,
  input  logic [15:0] iSRAM_DQ,
  output logic [15:0] oPIXEL,
  output logic        oPIXEL_VALID,
  input  logic        iPIXEL_READY,
  output logic [15:0] oUNDERRUN_CNT
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FILL, STREAM} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state, state_nxt;
  logic [SRAM_LATENCY-1:0] slot_vld_p, slot_blk_p;
  logic [15:0]       buf_mem [OUT_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     outstanding;
  logic              pop, buf_wr, buf_rd;

  // outstanding = occupancy + inflight, so one compare enforces the credit limit
  assign pop    = ~RESET & ~iREADY_N & (outstanding < CW'(OUT_DEPTH));
  assign oREAD  = pop;
  assign buf_wr = slot_vld_p[SRAM_LATENCY-1];
  assign buf_rd = oPIXEL_VALID & iPIXEL_READY;
  assign oPIXEL = (occupancy != '0) ? buf_mem[rd_ptr] : 16'h0000;

  // Issue stage: launch the SRAM read for valid addresses only
  always_ff @(posedge CLK) begin
    if (RESET) begin
      oSRAM_ADDR <= 20'h00000;
      oSRAM_OE_N <= 1'b1;
    end else begin
      oSRAM_OE_N <= ~(pop & iADDRESS[19]);
      if (pop & iADDRESS[19])
        oSRAM_ADDR <= {1'b0, iADDRESS[18:0]};
    end
  end

  // Return pipeline: slot markers track each pop until its data is sampled
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_vld_p <= '0;
    end else begin
      slot_vld_p[0] <= pop;
      for (int i = 1; i < SRAM_LATENCY; i++)
        slot_vld_p[i] <= slot_vld_p[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    slot_blk_p[0] <= ~iADDRESS[19];
    for (int i = 1; i < SRAM_LATENCY; i++)
      slot_blk_p[i] <= slot_blk_p[i-1];
  end

  // Output buffer stage
  always_ff @(posedge CLK) begin
    if (buf_wr)
      buf_mem[wr_ptr] <= slot_blk_p[SRAM_LATENCY-1] ? BLACK_PIXEL : iSRAM_DQ;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
    end else begin
      if (buf_wr) wr_ptr <= wr_ptr + AW'(1);
      if (buf_rd) rd_ptr <= rd_ptr + AW'(1);
      occupancy   <= occupancy + CW'(buf_wr) - CW'(buf_rd);
      outstanding <= outstanding + CW'(pop) - CW'(buf_rd);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == FILL && occupancy >= CW'(PRIME_LEVEL))
      state_nxt = STREAM;
  end

  always_comb begin
    oPIXEL_VALID = (state == STREAM) && (occupancy != '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      oUNDERRUN_CNT <= 16'h0000;
    else if (state == STREAM && iPIXEL_READY && occupancy == '0)
      oUNDERRUN_CNT <= sat_inc16(oUNDERRUN_CNT);
  end

endmodule
